// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg: shared types for the SIPO frame controller.
// Holds the FSM state encoding and the state enum.
package sipo_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: WIDTH-bit right shift register, new bit at MSB.
// Ports: clk, reset (async high), en (shift), clr (sync clear, wins), sin, q.
module sipo_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= {sin, q_q[WIDTH-1:1]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: LSB-first serial frame collector with valid/ready output.
// Ports: clk, reset (async high), sin/sin_valid/sin_start in; out_data/
// out_valid out, out_ready in; busy, framing_err, overrun, parity_err out.
// Optional even parity bit after the data: define SIPO_PARITY_EN.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] word;
  logic             shift_en;
  logic             done;
  logic             complete;
  logic             ferr;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovr;
  logic             ferr_q;
  logic             ovr_q;

  sipo_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .clr   (done),
    .sin   (sin),
    .q     (shreg)
  );

  // Word as it will look once the current bit is shifted in; the
  // output register captures this directly so the word is out one
  // cycle after its last bit.
  assign word_nxt = {sin, shreg[WIDTH-1:1]};

`ifdef SIPO_PARITY_EN
  logic perr;
  logic perr_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    done     = 1'b0;
    complete = 1'b0;
    word     = shreg;
    ferr     = 1'b0;
`ifdef SIPO_PARITY_EN
    perr     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sin_valid && sin_start) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shift_en = 1'b1;
          if (sin_start) begin
            // Restart; stale bits get shifted out by the new frame.
            ferr  = 1'b1;
            cnt_d = CNT_W'(1);
          end else if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SIPO_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            done     = 1'b1;
            complete = 1'b1;
            word     = word_nxt;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (sin_valid) begin
          if (sin_start) begin
            ferr     = 1'b1;
            shift_en = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
            if (^{shreg, sin}) begin
              perr = 1'b1;
            end else begin
              complete = 1'b1;
              word     = shreg;
            end
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovr         = 1'b0;
    if (complete) begin
      if (out_valid_q && !out_ready) begin
        ovr = 1'b1;
      end else begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ferr_q      <= ferr;
      ovr_q       <= ovr;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: scoreboard bench for sipo_frame_ctrl, WIDTH=4.
// Expected words queued at send time, popped on each accepted handshake.
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_start = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             framing_err;
  logic             overrun;
  logic             parity_err;

  int n_chk = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] sb[$];

  sipo_frame_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        check("sb_data", 32'(out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic st);
    tick();
    sin       = b;
    sin_valid = 1'b1;
    sin_start = st;
  endtask

  task automatic idle();
    tick();
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w,
                            input logic rdy_last);
    logic pb;
    for (int i = 0; i < WIDTH; i++) begin
      drive(w[i], i == 0);
`ifndef SIPO_PARITY_EN
      if (rdy_last && i == WIDTH - 1) out_ready = 1'b1;
`endif
    end
`ifdef SIPO_PARITY_EN
    pb = ^w;
    drive(pb, 1'b0);
    if (rdy_last) out_ready = 1'b1;
`else
    pb = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] w;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();

    // 1: basic frame, latency one
    out_ready = 1'b1;
    sb.push_back(4'b1101);
    send_frame(4'b1101, 1'b0);
    check("t1_not_early", out_valid, 0);
    check("t1_busy", busy, 1);
    idle();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 4'hD);
    check("t1_idle", busy, 0);
    tick();
    check("t1_drop", out_valid, 0);

    // 2: overrun while held
    out_ready = 1'b0;
    sb.push_back(4'hA);
    send_frame(4'hA, 1'b0);
    idle();
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 4'hA);
    send_frame(4'h5, 1'b0);
    idle();
    check("t2_ovr", overrun, 1);
    check("t2_hold", out_data, 4'hA);
    check("t2_vhold", out_valid, 1);
    tick();
    check("t2_ovr_pulse", overrun, 0);
    out_ready = 1'b1;
    tick();
    check("t2_taken", out_valid, 0);

    // 3: framing error restart
    sb.push_back(4'hF);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    check("t3_ferr", framing_err, 1);
    check("t3_busy", busy, 1);
    drive(1'b1, 1'b0);
    check("t3_ferr_pulse", framing_err, 0);
    drive(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    drive(1'b0, 1'b0);
`endif
    idle();
    check("t3_valid", out_valid, 1);
    check("t3_data", out_data, 4'hF);
    tick();

    // 4: complete during handshake
    out_ready = 1'b0;
    sb.push_back(4'h6);
    send_frame(4'h6, 1'b0);
    idle();
    check("t4_first", out_data, 4'h6);
    sb.push_back(4'h9);
    send_frame(4'h9, 1'b1);
    idle();
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 4'h9);
    check("t4_no_ovr", overrun, 0);
    tick();
    check("t4_taken", out_valid, 0);

    // 5: reset mid-frame
    out_ready = 1'b0;
    send_frame(4'h3, 1'b0);
    idle();
    check("t5_held", out_valid, 1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    tick();
    check("t5_busy_pre", busy, 1);
    sin_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_data", out_data, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    sb.push_back(4'hC);
    send_frame(4'hC, 1'b0);
    idle();
    check("t5_valid2", out_valid, 1);
    check("t5_data2", out_data, 4'hC);
    tick();

`ifdef SIPO_PARITY_EN
    // 6: parity match and mismatch
    sb.push_back(4'h3);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    idle();
    check("t6_valid", out_valid, 1);
    check("t6_perr0", parity_err, 0);
    tick();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    idle();
    check("t6_perr", parity_err, 1);
    check("t6_novalid", out_valid, 0);
    tick();
    check("t6_perr_pulse", parity_err, 0);
`else
    check("t6_perr_tied", parity_err, 0);
`endif

    // random back-to-back frames
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = WIDTH'($urandom_range(0, 15));
      sb.push_back(w);
      send_frame(w, 1'b0);
    end
    idle();
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
